// File: rtl/sram_req_ctrl.sv
// Request/response front end for a single-port SRAM macro: registered macro
// controls, in-order read return through a credit-limited FWFT FIFO, and an array clear sequencer.
module sram_req_ctrl #(
  parameter int                ADDR_W     = 10,
  parameter int                DATA_W     = 32,
  parameter int                RSP_DEPTH  = 4,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  input  logic                  init_start,
  output logic                  init_busy,
  output logic                  init_done,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_din,
  output logic [DATA_W-1:0]     sram_bm,
  output logic                  sram_men,
  output logic                  sram_wen,
  output logic                  sram_ren,
  input  logic [DATA_W-1:0]     sram_dout
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int UW    = CNT_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic {IDLE, INIT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   init_cnt;
  logic                init_last;
  logic                accept;
  logic                vld_p1, vld_p2;
  logic [UW-1:0]       used;

  logic [DATA_W-1:0]   fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                push, pop;

  function automatic logic [DATA_W-1:0] be_to_bm(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] bm;
    bm = '0;
    for (int i = 0; i < BE_W; i++) bm[i*8 +: 8] = {8{be[i]}};
    return bm;
  endfunction

  // Credits cover reads still in the macro pipeline plus queued responses,
  // so every accepted read is guaranteed a FIFO slot when its data lands.
  assign used      = UW'(fifo_cnt) + UW'(vld_p1) + UW'(vld_p2);
  assign req_ready = !rst && (state == IDLE) && !init_start && (used < UW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign init_last = (state == INIT) && (init_cnt == ADDR_MAX);
  assign init_busy = (state == INIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (init_start) state_nxt = INIT;
      INIT:    if (init_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= init_last;
      if ((state == INIT) && !init_last) init_cnt <= init_cnt + ADDR_W'(1);
      else                               init_cnt <= '0;
    end
  end

  // Stage p1: registered macro command; address/data/mask hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_men  <= 1'b0;
      sram_wen  <= 1'b0;
      sram_ren  <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      sram_bm   <= '0;
    end else begin
      sram_men <= 1'b0;
      sram_wen <= 1'b0;
      sram_ren <= 1'b0;
      if (state == INIT) begin
        sram_men  <= 1'b1;
        sram_wen  <= 1'b1;
        sram_addr <= init_cnt;
        sram_din  <= INIT_VALUE;
        sram_bm   <= '1;
      end else if (accept) begin
        sram_men  <= 1'b1;
        sram_wen  <= req_we;
        sram_ren  <= !req_we;
        sram_addr <= req_addr;
        sram_din  <= req_wdata;
        sram_bm   <= req_we ? be_to_bm(req_be) : '1;
      end
    end
  end

  // Stage p2: DOUT valid for the read issued in p1; captured at the end of p2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= accept && !req_we;
      vld_p2 <= vld_p1;
    end
  end

  assign push      = vld_p2;
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sram_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Fabric user-design block that sits directly upstream of the 1024x32 SRAM macro.
- Converts a valid/ready request stream (read/write, byte enables) into the macro's active-high MEN/WEN/REN/BM/ADDR/DIN controls.
- Captures DOUT into an in-order response FIFO and returns it over a valid/ready response port.
- Includes a hardware sequencer that clears the whole array to a constant.

Parameters:
- ADDR_W, 10, word address width; the array holds 2**ADDR_W words.
- DATA_W, 32, data width; must be a multiple of 8.
- RSP_DEPTH, 4, response FIFO depth; also the read credit limit. Power of 2, minimum 2.
- INIT_VALUE, 0, word written by the clear sequencer.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at the clock edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables, active-high.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data, returned in request order.
- init_start  in  1  one-cycle pulse that starts an array clear.
- init_busy  out  1  clear sequencer running.
- init_done  out  1  one-cycle pulse when the clear completes.
- sram_addr  out  ADDR_W  to macro ADDR.
- sram_din  out  DATA_W  to macro DIN.
- sram_bm  out  DATA_W  to macro BM; each req_be bit replicated to 8 BM bits.
- sram_men, sram_wen, sram_ren  out  1 each  to macro MEN/WEN/REN.
- sram_dout  in  DATA_W  from macro DOUT.

Behaviour:
- Reset: all outputs are 0. FIFO empty, state IDLE, in-flight reads discarded. Asserting reset mid-operation aborts immediately; no response is produced for discarded reads.
- Macro contract: commands are sampled at the clock edge. DOUT is valid during the cycle after a read command. All macro control outputs are registered.
- States: IDLE and INIT.
- req_ready = (state==IDLE) && !init_start && (inflight + fifo_count < RSP_DEPTH). inflight counts reads in pipeline stages S1 and S2. The same rule applies to writes.
- Accepted request, cycle N:
  - Cycle N+1: macro outputs carry the command. sram_men=1; sram_wen=req_we; sram_ren=!req_we; sram_bm from req_be for writes, all-ones for reads.
  - Read: sram_dout is pushed into the FIFO at the end of N+2. rsp_valid rises in N+3 if the FIFO was empty (latency 3).
  - Write: produces no response.
- Idle cycles drive sram_men=sram_wen=sram_ren=0; addr, din and bm hold their previous values.
- Back-to-back: one request per cycle is sustained while credits remain.
- Credit rule guarantees the FIFO never overflows. An accepted read always has a slot.
- Response FIFO: first-word-fall-through. rsp_rdata = head entry. Pop on rsp_valid && rsp_ready. Push and pop may occur in the same cycle; count is unchanged.
- Data is returned strictly in request order. rsp_rdata is stable while rsp_valid && !rsp_ready.
- A write followed by a read of the same address returns the new data. The macro is in order; no forwarding logic is needed.
- IDLE -> INIT on init_start in IDLE; this takes priority over a same-cycle req_valid, which is not accepted.
  - Reads already in flight complete and are returned normally.
- INIT sequencing:
  - init_busy=1.
  - The counter issues one full-mask write of INIT_VALUE per cycle, address 0 .. 2**ADDR_W-1.
  - The last write is issued in the cycle the counter equals max. The next cycle is IDLE, with init_done=1 for exactly one cycle and init_busy=0.
- init_start while in INIT is ignored.
- Counter and address wrap are not possible; the sequencer exits at max.

Test Plan:
- Write 0xDEADBEEF to addr 5 with be=4'hF, then read addr 5 with rsp_ready=1 -> sram_wen pulse with sram_bm=0xFFFFFFFF. rsp_valid exactly 3 cycles after read acceptance, rsp_rdata=0xDEADBEEF.
- Then write 0x0000AB00 to addr 5 with be=4'b0010, then read -> sram_bm=0x0000FF00, rsp_rdata=0xDEADABEF.
- Issue 6 back-to-back reads (addr 0..5, pre-written with addr*0x11111111) with rsp_ready=0 -> req_ready drops after 4 acceptances. Release rsp_ready -> 0x00000000 .. 0x55555555 returned in order, no loss or duplicate.
- Pulse init_start -> init_busy high for exactly 1024 cycles, sram_addr sweeps 0..1023, init_done pulses once. Then reading addr 0 and addr 1023 returns INIT_VALUE.
- Drive init_start and req_valid (read) in the same cycle -> request not accepted, INIT entered. The request is accepted on the first IDLE cycle after init_done.
- Assert rst with 2 reads in flight and 1 queued -> all outputs 0 immediately, rsp_valid stays 0 after release, req_ready=1 in the first cycle after rst deasserts.
